// File: rtl/inv_mix_columns_seq.sv
`default_nettype none
// ============================================================================
// Module      : inv_mix_columns_seq (with helper inv_mix_gf_mul)
// Description : Sequential AES-128 InvMixColumns. A 128-bit state is accepted
//               over a valid/ready handshake, its four columns are fed one per
//               cycle into a shared bank of 16 registered GF(2^8) constant
//               multipliers, and the combined column results are written into
//               the output register as they emerge from the multipliers.
// Ports       : Clk       rising-edge clock
//               Rst_n     asynchronous active-low reset
//               InValid   InData is valid
//               InReady   block can accept a state (IDLE only)
//               InData    128-bit state, column-major, byte 0 = [127:120]
//               OutValid  OutData holds a completed result
//               OutReady  downstream accepts the result
//               OutData   InvMixColumns(InData), same byte ordering
//               Busy      high while feeding or draining the multipliers
// Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// inv_mix_gf_mul: multiply a byte by a constant in GF(2^8) modulo
// x^8+x^4+x^3+x+1, followed by MUL_LATENCY register stages.
// Ports: Clk, Rst_n, InByte (operand), OutByte (registered product).
// ----------------------------------------------------------------------------
module inv_mix_gf_mul #(
    parameter logic [7:0] CONST       = 8'h09,
    parameter int         MUL_LATENCY = 1
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic [7:0] InByte,
    output logic [7:0] OutByte
);

    function automatic logic [7:0] gfMulConst(input logic [7:0] a, input logic [7:0] k);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (k[i]) acc = acc ^ p;
            p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    logic [7:0]                   w_prod;
    logic [MUL_LATENCY-1:0][7:0]  r_pipe;

    assign w_prod = gfMulConst(InByte, CONST);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_pipe <= '0;
        end else begin
            r_pipe[0] <= w_prod;
            for (int i = 1; i < MUL_LATENCY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign OutByte = r_pipe[MUL_LATENCY-1];

endmodule

// ----------------------------------------------------------------------------
// inv_mix_columns_seq: top level
// ----------------------------------------------------------------------------
module inv_mix_columns_seq #(
    parameter int MUL_LATENCY = 1
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic         InValid,
    output logic         InReady,
    input  logic [127:0] InData,
    output logic         OutValid,
    input  logic         OutReady,
    output logic [127:0] OutData,
    output logic         Busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int c_DRAIN_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
    localparam logic [c_DRAIN_W-1:0] c_DRAIN_LAST = c_DRAIN_W'(MUL_LATENCY - 1);

    state_t                      r_state;
    state_t                      w_nextState;
    logic [3:0][31:0]            r_inReg;      // index 3 holds column 0
    logic [3:0][31:0]            r_outData;
    logic [1:0]                  r_colCnt;
    logic [c_DRAIN_W-1:0]        r_drainCnt;
    logic [MUL_LATENCY-1:0]      r_tagValid;   // travels alongside the multiplier pipeline
    logic [MUL_LATENCY-1:0][1:0] r_tagCol;
    logic                        w_accept;
    logic [3:0][7:0]             w_col;        // index 3 holds row 0
    logic [3:0][7:0]             w_p9, w_pB, w_pD, w_pE;  // indexed by row number
    logic [3:0][7:0]             w_result;     // index 3 holds row 0

    assign w_accept = InValid && (r_state == ST_IDLE);
    assign w_col    = r_inReg[2'd3 - r_colCnt];

    // ---------------- FSM ----------------
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) r_state <= ST_IDLE;
        else        r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        InReady     = 1'b0;
        OutValid    = 1'b0;
        Busy        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                InReady = 1'b1;
                if (InValid) w_nextState = ST_FEED;
            end
            ST_FEED: begin
                Busy = 1'b1;
                if (r_colCnt == 2'd3) w_nextState = ST_DRAIN;
            end
            ST_DRAIN: begin
                Busy = 1'b1;
                if (r_drainCnt == c_DRAIN_LAST) w_nextState = ST_DONE;
            end
            ST_DONE: begin
                OutValid = 1'b1;
                if (OutReady) w_nextState = ST_IDLE;
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // ---------------- multiplier bank ----------------
    for (genvar gRow = 0; gRow < 4; gRow++) begin : g_row
        inv_mix_gf_mul #(.CONST(8'h09), .MUL_LATENCY(MUL_LATENCY)) u_mul9 (
            .Clk(Clk), .Rst_n(Rst_n), .InByte(w_col[3-gRow]), .OutByte(w_p9[gRow]));
        inv_mix_gf_mul #(.CONST(8'h0b), .MUL_LATENCY(MUL_LATENCY)) u_mulB (
            .Clk(Clk), .Rst_n(Rst_n), .InByte(w_col[3-gRow]), .OutByte(w_pB[gRow]));
        inv_mix_gf_mul #(.CONST(8'h0d), .MUL_LATENCY(MUL_LATENCY)) u_mulD (
            .Clk(Clk), .Rst_n(Rst_n), .InByte(w_col[3-gRow]), .OutByte(w_pD[gRow]));
        inv_mix_gf_mul #(.CONST(8'h0e), .MUL_LATENCY(MUL_LATENCY)) u_mulE (
            .Clk(Clk), .Rst_n(Rst_n), .InByte(w_col[3-gRow]), .OutByte(w_pE[gRow]));
    end

    assign w_result[3] = w_pE[0] ^ w_pB[1] ^ w_pD[2] ^ w_p9[3];
    assign w_result[2] = w_p9[0] ^ w_pE[1] ^ w_pB[2] ^ w_pD[3];
    assign w_result[1] = w_pD[0] ^ w_p9[1] ^ w_pE[2] ^ w_pB[3];
    assign w_result[0] = w_pB[0] ^ w_pD[1] ^ w_p9[2] ^ w_pE[3];

    // ---------------- datapath ----------------
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_inReg    <= '0;
            r_outData  <= '0;
            r_colCnt   <= '0;
            r_drainCnt <= '0;
            r_tagValid <= '0;
            r_tagCol   <= '0;
        end else begin
            if (w_accept) begin
                r_inReg  <= InData;
                r_colCnt <= 2'd0;
            end else if (r_state == ST_FEED) begin
                // Natural 3->0 wrap coincides with the move to DRAIN.
                r_colCnt <= r_colCnt + 2'd1;
            end

            if (r_state == ST_DRAIN) r_drainCnt <= r_drainCnt + c_DRAIN_W'(1);
            else                     r_drainCnt <= '0;

            // Column tag enters the pipeline when the multipliers sample the column.
            r_tagValid[0] <= (r_state == ST_FEED);
            r_tagCol[0]   <= r_colCnt;
            for (int i = 1; i < MUL_LATENCY; i++) begin
                r_tagValid[i] <= r_tagValid[i-1];
                r_tagCol[i]   <= r_tagCol[i-1];
            end

            if (r_tagValid[MUL_LATENCY-1]) begin
                r_outData[2'd3 - r_tagCol[MUL_LATENCY-1]] <= w_result;
            end
        end
    end

    assign OutData = r_outData;

endmodule
`default_nettype wire

// File: tb/tb_inv_mix_columns_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_inv_mix_columns_seq
// Description : Self-checking bench for inv_mix_columns_seq. A matrix-based
//               GF(2^8) reference model supplies expected results; a second
//               instance built with MUL_LATENCY=2 checks the latency scaling.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inv_mix_columns_seq;

    localparam logic [127:0] V1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] E1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] V2 = 128'h4d7ebdf8_d5d5d7d6_00000000_ffffffff;
    localparam logic [127:0] E2 = 128'h2d26314c_d4d4d4d5_00000000_ffffffff;

    logic         clk = 1'b0;
    logic         rstN;
    logic         inValid, inReady, outValid, outReady, busy;
    logic [127:0] inData, outData;
    logic         inValid2, inReady2, outValid2, outReady2, busy2;
    logic [127:0] inData2, outData2;

    int nVec = 0;
    int nErr = 0;

    always #5 clk = ~clk;

    inv_mix_columns_seq #(.MUL_LATENCY(1)) dut (
        .Clk(clk), .Rst_n(rstN), .InValid(inValid), .InReady(inReady), .InData(inData),
        .OutValid(outValid), .OutReady(outReady), .OutData(outData), .Busy(busy));

    inv_mix_columns_seq #(.MUL_LATENCY(2)) dut2 (
        .Clk(clk), .Rst_n(rstN), .InValid(inValid2), .InReady(inReady2), .InData(inData2),
        .OutValid(outValid2), .OutReady(outReady2), .OutData(outData2), .Busy(busy2));

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] prod;
        prod = 16'h0;
        for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (16'(a) << i);
        for (int k = 15; k >= 8; k--) if (prod[k]) prod = prod ^ (16'h011b << (k - 8));
        return prod[7:0];
    endfunction

    function automatic logic [127:0] invMix(input logic [127:0] s);
        logic [7:0]   coef [4];
        logic [127:0] r;
        logic [7:0]   acc;
        coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(s[127 - 32*c - 8*j -: 8], coef[(j - i + 4) % 4]);
                r[127 - 32*c - 8*i -: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a state at a negedge; returns at the negedge after the accepting edge.
    task automatic accept(input logic [127:0] d);
        check("accept_ready", 128'(inReady), 128'(1));
        inValid = 1'b1;
        inData  = d;
        @(negedge clk);
        inValid = 1'b0;
    endtask

    task automatic waitOut(output int n);
        n = 0;
        while (!outValid && n < 60) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int           n;
        int           pulses;
        logic [127:0] s, held, got;

        rstN = 1'b0; inValid = 1'b0; inData = '0; outReady = 1'b0;
        inValid2 = 1'b0; inData2 = '0; outReady2 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_inReady", 128'(inReady), 128'(1));
        check("rst_outValid", 128'(outValid), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_outData", outData, '0);
        rstN = 1'b1;
        @(negedge clk);

        // Single state, latency and handshake
        accept(V1);
        check("t1_busy", 128'(busy), 128'(1));
        waitOut(n);
        check("t1_latency", 128'(n), 128'(5));
        check("t1_data", outData, E1);
        outReady = 1'b1;
        @(negedge clk);
        check("t1_outValid_drop", 128'(outValid), 128'(0));
        check("t1_inReady_rise", 128'(inReady), 128'(1));
        check("t1_busy_idle", 128'(busy), 128'(0));

        // Back-to-back with OutReady held high
        inValid = 1'b1; inData = V1;
        @(negedge clk);
        inData = V2;
        n = 0; got = '0;
        while (!inReady && n < 60) begin
            if (outValid) got = outData;
            @(negedge clk);
            n++;
        end
        check("t2_gap", 128'(n), 128'(6));
        check("t2_dataA", got, E1);
        @(negedge clk);
        inValid = 1'b0;
        waitOut(n);
        check("t2_latencyB", 128'(n), 128'(5));
        check("t2_dataB", outData, E2);
        check("t2_modelB", outData, invMix(V2));
        @(negedge clk);
        check("t2_outValid_drop", 128'(outValid), 128'(0));
        outReady = 1'b0;

        // Output stall with ignored input traffic
        s = rnd128();
        accept(s);
        waitOut(n);
        held = outData;
        check("t3_data", held, invMix(s));
        for (int k = 0; k < 20; k++) begin
            inValid = $urandom_range(0, 1);
            inData  = rnd128();
            @(negedge clk);
            check("t3_stall_valid", 128'(outValid), 128'(1));
            check("t3_stall_data", outData, held);
            check("t3_stall_inReady", 128'(inReady), 128'(0));
        end
        inValid = 1'b0;
        outReady = 1'b1;
        @(negedge clk);
        outReady = 1'b0;
        check("t3_release_valid", 128'(outValid), 128'(0));
        check("t3_release_inReady", 128'(inReady), 128'(1));
        check("t3_retain_data", outData, held);

        // Input toggling while busy
        accept(V1);
        repeat (4) begin
            inValid = $urandom_range(0, 1);
            inData  = rnd128();
            @(negedge clk);
        end
        inValid = 1'b0;
        waitOut(n);
        check("t4_data", outData, E1);
        outReady = 1'b1;
        @(negedge clk);
        outReady = 1'b0;
        pulses = 0;
        repeat (10) begin
            if (outValid) pulses++;
            @(negedge clk);
        end
        check("t4_extra_pulse", 128'(pulses), 128'(0));

        // Random states with random downstream stalls
        for (int k = 0; k < 6; k++) begin
            s = rnd128();
            accept(s);
            waitOut(n);
            check("t5_latency", 128'(n), 128'(5));
            check("t5_data", outData, invMix(s));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            outReady = 1'b1;
            @(negedge clk);
            outReady = 1'b0;
        end

        // Asynchronous reset while feeding column 2
        accept(V2);
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b0;
        #1;
        check("t6_rst_outValid", 128'(outValid), 128'(0));
        check("t6_rst_inReady", 128'(inReady), 128'(1));
        check("t6_rst_outData", outData, '0);
        check("t6_rst_busy", 128'(busy), 128'(0));
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        accept(V1);
        waitOut(n);
        check("t6_latency", 128'(n), 128'(5));
        check("t6_data", outData, E1);
        outReady = 1'b1;
        @(negedge clk);
        outReady = 1'b0;

        // MUL_LATENCY=2 instance
        check("t7_ready", 128'(inReady2), 128'(1));
        inValid2 = 1'b1;
        inData2  = V1;
        @(negedge clk);
        inValid2 = 1'b0;
        n = 0;
        while (!outValid2 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("t7_latency", 128'(n), 128'(6));
        check("t7_data", outData2, E1);
        outReady2 = 1'b1;
        @(negedge clk);
        check("t7_outValid_drop", 128'(outValid2), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
`default_nettype wire
